axi_lite_reg_bank: RTL and testbench

//   Parametrised AXI4-Lite slave register bank; successor to the fixed 3-register config slave.

---
 rtl/axi_lite_reg_pkg.sv | 27 ++
 rtl/axi_lite_reg_bank.sv | 180 ++++++++++++++++++
 tb/tb_axi_lite_reg_bank.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_pkg.sv
// Shared definitions for AXI4-Lite BAR slaves: response codes and byte-enable merge.
// Latency: none (constants and a pure combinational function).
// Backpressure: not applicable.
package axi_lite_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widest register the merge helper handles; callers zero-extend into it and truncate back.
  localparam int DATA_MAX = 256;
  localparam int STRB_MAX = DATA_MAX / 8;

  // Replace byte k of old_dat with byte k of new_dat wherever strb[k] is set.
  function automatic logic [DATA_MAX-1:0] strb_merge(
    input logic [DATA_MAX-1:0] old_dat,
    input logic [DATA_MAX-1:0] new_dat,
    input logic [STRB_MAX-1:0] strb
  );
    logic [DATA_MAX-1:0] res;
    res = old_dat;
    for (int k = 0; k < STRB_MAX; k++) begin
      if (strb[k]) res[k*8 +: 8] = new_dat[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank: NUM_CFG read/write config regs followed by NUM_STAT read-only status regs.
// Latency: a write commits on the edge that completes the later of AW/W (cfg, pulse, B visible next cycle); R is valid the cycle after AR.
// Backpressure: AW/W stall while their 1-deep hold is full or B is pending; AR stalls while R is pending.
// Ports: axi_clk/axi_rst (sync, active high); AXI4-Lite AW/W/B/AR/R channels (awprot/arprot ignored);
//   cfg_regs (reg i at [i*DATA_WIDTH +: DATA_WIDTH]); cfg_wr_pulse (one bit per cfg reg, 1 cycle on commit);
//   stat_regs (status reg j at [j*DATA_WIDTH +: DATA_WIDTH], sampled on the AR handshake).
module axi_lite_reg_bank
  import axi_lite_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CFG    = 3,
  parameter int NUM_STAT   = 2,
  parameter logic [DATA_WIDTH-1:0] CFG_RST_VAL = '0
) (
  input  logic                           axi_clk,
  input  logic                           axi_rst,
  input  logic [ADDR_WIDTH-1:0]          axi_awaddr,
  input  logic [2:0]                     axi_awprot,
  input  logic                           axi_awvalid,
  output logic                           axi_awready,
  input  logic [DATA_WIDTH-1:0]          axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        axi_wstrb,
  input  logic                           axi_wvalid,
  output logic                           axi_wready,
  output logic [1:0]                     axi_bresp,
  output logic                           axi_bvalid,
  input  logic                           axi_bready,
  input  logic [ADDR_WIDTH-1:0]          axi_araddr,
  input  logic [2:0]                     axi_arprot,
  input  logic                           axi_arvalid,
  output logic                           axi_arready,
  output logic [DATA_WIDTH-1:0]          axi_rdata,
  output logic [1:0]                     axi_rresp,
  output logic                           axi_rvalid,
  input  logic                           axi_rready,
  output logic [NUM_CFG*DATA_WIDTH-1:0]  cfg_regs,
  output logic [NUM_CFG-1:0]             cfg_wr_pulse,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_regs
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;

  if (NUM_CFG < 1 || NUM_CFG + NUM_STAT > 2**IDX_W || DATA_WIDTH % 8 != 0 || DATA_WIDTH > DATA_MAX)
  begin : g_bad_params
    $error("axi_lite_reg_bank: illegal parameter combination");
  end

  // Low after reset until the first non-reset edge, keeping all readies low while in reset.
  logic                  alive_q;
  logic                  aw_full_q;
  logic                  w_full_q;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_dat_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] cfg_q [NUM_CFG];
  logic [NUM_CFG-1:0]    pulse_q;

  logic                  aw_hs, w_hs, ar_hs, commit, wr_ok;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_dat, rd_dat;
  logic [STRB_W-1:0]     wr_strb;
  logic [1:0]            rd_resp;
  logic [DATA_WIDTH-1:0] wr_merged [NUM_CFG];
  logic                  unused_ok;

  assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

  assign axi_awready = alive_q & ~aw_full_q & ~bvalid_q;
  assign axi_wready  = alive_q & ~w_full_q  & ~bvalid_q;
  assign axi_arready = alive_q & ~rvalid_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rresp   = rresp_q;
  assign axi_rdata   = rdata_q;
  assign cfg_wr_pulse = pulse_q;

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
    assign cfg_regs[g*DATA_WIDTH +: DATA_WIDTH] = cfg_q[g];
  end

  assign aw_hs = axi_awvalid & axi_awready;
  assign w_hs  = axi_wvalid  & axi_wready;
  assign ar_hs = axi_arvalid & axi_arready;

  // A held beat takes priority over the bus: the bus side is not ready while its hold is full.
  assign wr_idx  = aw_full_q ? aw_idx_q : axi_awaddr[ADDR_WIDTH-1:2];
  assign wr_dat  = w_full_q  ? w_dat_q  : axi_wdata;
  assign wr_strb = w_full_q  ? w_strb_q : axi_wstrb;
  assign commit  = (aw_full_q | aw_hs) & (w_full_q | w_hs);
  assign wr_ok   = {1'b0, wr_idx} < (IDX_W+1)'(NUM_CFG);

  always_comb begin
    for (int i = 0; i < NUM_CFG; i++) begin
      wr_merged[i] = DATA_WIDTH'(strb_merge(DATA_MAX'(cfg_q[i]), DATA_MAX'(wr_dat), STRB_MAX'(wr_strb)));
    end
  end

  // Read mux; cfg_q here is the pre-commit value when a write commits on the same edge.
  assign rd_idx = axi_araddr[ADDR_WIDTH-1:2];
  always_comb begin
    rd_dat  = '0;
    rd_resp = RESP_SLVERR;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_dat  = cfg_q[i];
        rd_resp = RESP_OKAY;
      end
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (rd_idx == IDX_W'(NUM_CFG + j)) begin
        rd_dat  = stat_regs[j*DATA_WIDTH +: DATA_WIDTH];
        rd_resp = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      alive_q   <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_dat_q   <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= CFG_RST_VAL;
    end else begin
      alive_q <= 1'b1;
      pulse_q <= '0;

      if (bvalid_q && axi_bready) bvalid_q <= 1'b0;

      // Commit can only occur with B idle, since both holds only fill while bvalid is low.
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_CFG; i++) begin
          if (wr_idx == IDX_W'(i)) begin
            cfg_q[i]   <= wr_merged[i];
            pulse_q[i] <= 1'b1;
          end
        end
      end else begin
        if (aw_hs) begin
          aw_full_q <= 1'b1;
          aw_idx_q  <= axi_awaddr[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_full_q <= 1'b1;
          w_dat_q  <= axi_wdata;
          w_strb_q <= axi_wstrb;
        end
      end

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_dat;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Self-checking bench for axi_lite_reg_bank (6-bit address, 32-bit data, 3 cfg + 2 status regs).
// Latency: directed steps, then randomized reads/writes against a register-map model.
// Backpressure: exercised through delayed W/AW and held-off bready/rready.
module tb_axi_lite_reg_bank;

  logic        axi_clk = 1'b0;
  logic        axi_rst = 1'b1;
  logic [5:0]  axi_awaddr = '0;
  logic [2:0]  axi_awprot = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;
  logic [5:0]  axi_araddr = '0;
  logic [2:0]  axi_arprot = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;
  logic [95:0] cfg_regs;
  logic [2:0]  cfg_wr_pulse;
  logic [63:0] stat_regs;

  int checks = 0;
  int errors = 0;

  // Reference model: the register map as plain arrays.
  logic [31:0] cfg_m  [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] stat_m [2] = '{32'h0, 32'h0};

  assign stat_regs = {stat_m[1], stat_m[0]};

  always #5 axi_clk = ~axi_clk;

  axi_lite_reg_bank #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_CFG(3), .NUM_STAT(2), .CFG_RST_VAL(32'h0)
  ) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .cfg_regs(cfg_regs), .cfg_wr_pulse(cfg_wr_pulse), .stat_regs(stat_regs)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_clk);
    #1;
  endtask

  function automatic logic [95:0] cfg_exp();
    return {cfg_m[2], cfg_m[1], cfg_m[0]};
  endfunction

  task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] mask;
    mask = 32'h0;
    if (idx < 3) begin
      for (int k = 0; k < 4; k++) if (strb[k]) mask = mask | (32'hFF << (8 * k));
      cfg_m[idx] = (cfg_m[idx] & ~mask) | (data & mask);
    end
  endtask

  task automatic model_read(input int idx, output logic [31:0] d, output logic [1:0] r);
    if (idx < 3) begin
      d = cfg_m[idx]; r = 2'b00;
    end else if (idx < 5) begin
      d = stat_m[idx - 3]; r = 2'b00;
    end else begin
      d = 32'h0; r = 2'b10;
    end
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done, w_done, aw_h, w_h;
    int cyc, idx;
    logic [2:0] exp_pulse;
    aw_done = 0; w_done = 0; cyc = 0;
    idx = int'(addr[5:2]);
    axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      axi_awvalid = !aw_done && (cyc >= aw_dly);
      axi_wvalid  = !w_done && (cyc >= w_dly);
      aw_h = axi_awvalid && axi_awready;
      w_h  = axi_wvalid && axi_wready;
      step();
      if (aw_h) aw_done = 1;
      if (w_h) w_done = 1;
      cyc++;
      if (!(aw_done && w_done)) begin
        chk("wr_wait_bvalid", 96'(axi_bvalid), 96'(0));
        chk("wr_wait_cfg", cfg_regs, cfg_exp());
        if (aw_done) chk("wr_wait_awready", 96'(axi_awready), 96'(0));
        if (w_done) chk("wr_wait_wready", 96'(axi_wready), 96'(0));
      end
    end
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    chk("wr_handshake_timeout", 96'({aw_done, w_done}), 96'(2'b11));
    model_write(idx, data, strb);
    exp_pulse = (idx < 3) ? 3'(1 << idx) : 3'b000;
    chk("wr_bvalid", 96'(axi_bvalid), 96'(1));
    chk("wr_bresp", 96'(axi_bresp), 96'((idx < 3) ? 2'b00 : 2'b10));
    chk("wr_pulse", 96'(cfg_wr_pulse), 96'(exp_pulse));
    chk("wr_cfg", cfg_regs, cfg_exp());
    for (int i = 0; i < b_dly; i++) begin
      step();
      chk("b_hold_bvalid", 96'(axi_bvalid), 96'(1));
      chk("b_hold_bresp", 96'(axi_bresp), 96'((idx < 3) ? 2'b00 : 2'b10));
      chk("b_hold_awready", 96'(axi_awready), 96'(0));
      chk("b_hold_pulse", 96'(cfg_wr_pulse), 96'(0));
    end
    axi_bready = 1'b1;
    step();
    axi_bready = 1'b0;
    chk("b_done_bvalid", 96'(axi_bvalid), 96'(0));
    chk("b_done_pulse", 96'(cfg_wr_pulse), 96'(0));
    chk("b_done_ready", 96'({axi_awready, axi_wready}), 96'(2'b11));
  endtask

  task automatic do_read(input logic [5:0] addr, input int r_dly);
    logic [31:0] ed;
    logic [1:0]  er;
    int cyc;
    cyc = 0;
    axi_araddr = addr; axi_arvalid = 1'b1;
    while (!axi_arready && cyc < 50) begin
      step();
      cyc++;
    end
    chk("rd_arready_timeout", 96'(axi_arready), 96'(1));
    model_read(int'(addr[5:2]), ed, er);
    step();
    axi_arvalid = 1'b0;
    chk("rd_rvalid", 96'(axi_rvalid), 96'(1));
    chk("rd_rdata", 96'(axi_rdata), 96'(ed));
    chk("rd_rresp", 96'(axi_rresp), 96'(er));
    for (int i = 0; i < r_dly; i++) begin
      step();
      chk("r_hold_rvalid", 96'(axi_rvalid), 96'(1));
      chk("r_hold_rdata", 96'(axi_rdata), 96'(ed));
      chk("r_hold_arready", 96'(axi_arready), 96'(0));
    end
    axi_rready = 1'b1;
    step();
    axi_rready = 1'b0;
    chk("r_done_rvalid", 96'(axi_rvalid), 96'(0));
    chk("r_done_arready", 96'(axi_arready), 96'(1));
  endtask

  initial begin
    // Reset held for two cycles.
    axi_rst = 1'b1;
    step();
    step();
    chk("rst_readies", 96'({axi_awready, axi_wready, axi_arready}), 96'(3'b000));
    chk("rst_valids", 96'({axi_bvalid, axi_rvalid}), 96'(2'b00));
    chk("rst_cfg", cfg_regs, 96'(0));
    chk("rst_pulse", 96'(cfg_wr_pulse), 96'(0));
    chk("rst_rdata", 96'(axi_rdata), 96'(0));
    axi_rst = 1'b0;
    step();
    chk("post_rst_readies", 96'({axi_awready, axi_wready, axi_arready}), 96'(3'b111));

    // Same-cycle AW+W with a single byte strobe.
    do_write(6'h04, 32'h12345678, 4'b0010, 0, 0, 0);
    chk("cfg1_byte1", 96'(cfg_regs[63:32]), 96'(32'h00005600));

    // W arrives three cycles after AW; B held off four cycles.
    do_write(6'h08, 32'hFFAABBCC, 4'b1111, 0, 3, 4);

    // Writes to a status reg and to an unmapped word.
    do_write(6'h0C, 32'hDEADBEEF, 4'b1111, 0, 0, 0);
    do_write(6'h18, 32'hDEADBEEF, 4'b1111, 1, 0, 1);

    // Status and unmapped reads, with rready held low.
    stat_m[0] = 32'hCAFE0000;
    stat_m[1] = 32'hBEEF0001;
    do_read(6'h0C, 3);
    do_read(6'h10, 0);
    do_read(6'h14, 3);
    // Unaligned address maps to the containing word; zero strobe still pulses.
    do_read(6'h05, 0);
    do_write(6'h02, 32'h99999999, 4'b0000, 0, 0, 0);

    // Read and write commit to reg 0 on the same edge.
    do_write(6'h00, 32'h11223344, 4'hF, 0, 0, 0);
    axi_awaddr = 6'h00; axi_wdata = 32'hA5A5A5A5; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    axi_araddr = 6'h00; axi_arvalid = 1'b1;
    chk("same_cycle_readies", 96'({axi_awready, axi_wready, axi_arready}), 96'(3'b111));
    step();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
    chk("same_cycle_rvalid", 96'(axi_rvalid), 96'(1));
    chk("same_cycle_old_rdata", 96'(axi_rdata), 96'(cfg_m[0]));
    model_write(0, 32'hA5A5A5A5, 4'hF);
    chk("same_cycle_cfg", cfg_regs, cfg_exp());
    chk("same_cycle_pulse", 96'(cfg_wr_pulse), 96'(3'b001));
    axi_bready = 1'b1; axi_rready = 1'b1;
    step();
    axi_bready = 1'b0; axi_rready = 1'b0;
    chk("same_cycle_done", 96'({axi_bvalid, axi_rvalid}), 96'(2'b00));
    do_read(6'h00, 0);

    // Randomized mix of reads and writes against the model.
    for (int n = 0; n < 60; n++) begin
      logic [5:0] a;
      a = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 23)) : 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end else begin
        stat_m[0] = $urandom;
        stat_m[1] = $urandom;
        do_read(a, int'($urandom_range(0, 2)));
      end
    end

    // Reset during a pending B response.
    axi_awaddr = 6'h04; axi_wdata = 32'h0BADF00D; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    step();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    chk("midb_bvalid_set", 96'(axi_bvalid), 96'(1));
    axi_rst = 1'b1;
    step();
    chk("midb_bvalid_dropped", 96'(axi_bvalid), 96'(0));
    chk("midb_cfg_reset", cfg_regs, 96'(0));
    axi_rst = 1'b0;
    for (int i = 0; i < 3; i++) cfg_m[i] = 32'h0;
    step();
    do_write(6'h04, 32'h0BADF00D, 4'hF, 0, 0, 0);
    do_read(6'h04, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a handshake loop stalls beyond its budget.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "global timeout");
  end

endmodule
